fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 95 +++++++++
 tb/tb_fifo_stream_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Pulls words from the read side of a synchronous FIFO (registered empty
//   flag, one-cycle read latency) and presents them as a valid/ready stream
//   through a two-entry skid buffer.  Reads are issued only when the buffer
//   is guaranteed to have room for the returning word, so no captured word
//   is ever dropped and a full-rate stream is sustained with m_ready held high.
//
// Ports
//   clk            in   clock, all state updates on posedge
//   rst_n          in   asynchronous active-low reset
//   fifo_cs        out  FIFO chip select (same as fifo_rd_en)
//   fifo_rd_en     out  FIFO read request (combinational)
//   fifo_data_out  in   FIFO read data, valid the cycle after a read edge
//   fifo_empty     in   FIFO empty flag
//   flush          in   synchronous discard of buffered and in-flight words
//   m_valid        out  stream word available
//   m_ready        in   downstream accepts the word when m_valid=1
//   m_data         out  stream data (head of skid buffer)
//   rd_count       out  count of words delivered on the stream (wraps)
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [15:0]           rd_count
);

  localparam int SKID_DEPTH = 2;

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [SKID_DEPTH];
  logic [15:0]           r_rd_count;

  logic       w_valid;
  logic       w_pop;
  logic [2:0] w_level;
  logic       w_rd_en;
  logic       w_wr_slot;

  always_comb begin
    w_valid = (r_occ != 2'd0);
    w_pop   = w_valid && m_ready;
    // Words that will occupy the buffer once this edge's pop retires and the
    // in-flight word lands; a new read is safe only if that leaves a slot.
    w_level = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    w_rd_en = rst_n && !fifo_empty && !flush && (w_level < 3'(SKID_DEPTH));
    // Captured word goes to the first free slot after this edge's pop shifts.
    w_wr_slot = (r_occ == 2'd2) || ((r_occ == 2'd1) && !w_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_rd_count <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (flush) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_occ      <= r_occ - {1'b0, w_pop} + {1'b0, r_inflight};
      if (w_pop) begin
        r_buf[0]   <= r_buf[1];
        r_rd_count <= r_rd_count + 16'd1;
      end
      // Capture after the shift so a simultaneous pop keeps FIFO order.
      if (r_inflight) begin
        if (w_wr_slot) begin
          r_buf[1] <= fifo_data_out;
        end else begin
          r_buf[0] <= fifo_data_out;
        end
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign fifo_cs    = w_rd_en;
  assign m_valid    = w_valid;
  assign m_data     = r_buf[0];
  assign rd_count   = r_rd_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Directed and randomized bench for fifo_stream_reader.  A behavioural
//   synchronous FIFO feeds the DUT; a reference queue holds every word that
//   should appear on the stream, in order.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_cs;
  logic        fifo_rd_en;
  logic [31:0] fifo_data_out = '0;
  logic        fifo_empty = 1'b1;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [15:0] rd_count;

  logic        push_req = 1'b0;
  logic [31:0] push_data = '0;
  logic [31:0] fifo_q [$];
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_deliv = 0;
  int n_rd_seen = 0;
  int outstanding = 0;
  int first_rd = -1;
  int first_v = -1;
  int last_d = -1;
  bit gap_chk = 0;
  bit want_first = 0;
  logic [31:0] first_word = '0;
  bit prev_hold = 0;
  logic [31:0] prev_data = '0;

  fifo_stream_reader #(.DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_cs(fifo_cs),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty),
    .flush(flush),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered empty flag, data one cycle
  // after the read edge.  Also tracks words owned by the reader
  // (read but not yet delivered), which can never exceed the buffer size.
  always @(posedge clk) begin
    if (!rst_n || flush) outstanding <= 0;
    else outstanding <= outstanding + int'(fifo_rd_en) - int'(m_valid && m_ready);
    if (fifo_rd_en && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
    if (push_req) fifo_q.push_back(push_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic observe();
    logic [31:0] e;
    chk("cs_eq_rd_en", 32'(fifo_cs), 32'(fifo_rd_en));
    chk("level_le_2", 32'(outstanding <= 2), 32'd1);
    chk("rd_count", 32'(rd_count), n_deliv & 32'hFFFF);
    if (flush) chk("flush_no_read", 32'(fifo_rd_en), 32'd0);
    if (fifo_rd_en) begin
      n_rd_seen++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_v < 0) first_v = cyc;
    if (prev_hold) chk("hold_data", m_data, prev_data);
    if (m_valid && m_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("ref_queue_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("order", m_data, e);
      end
      if (want_first) begin
        first_word = m_data;
        want_first = 0;
      end
      if (gap_chk && last_d >= 0) chk("gap", 32'(cyc - last_d), 32'd1);
      last_d = cyc;
      n_deliv++;
    end
    prev_hold = m_valid && !m_ready && !flush;
    prev_data = m_data;
  endtask

  // Inputs for the current cycle are applied before calling step.
  task automatic step();
    #1;
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    m_ready = 1'b1;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) step();
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int pushes;
    int need;
    rst_n   = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;

    // Reset values
    #3;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_cs", 32'(fifo_cs), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate stream of 8 preloaded words
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(32'h1000_0000 + 32'(i));
      exp_q.push_back(32'h1000_0000 + 32'(i));
    end
    m_ready = 1'b1;
    gap_chk = 1;
    last_d  = -1;
    for (int c = 0; c < 40 && n_deliv < 8; c++) step();
    gap_chk = 0;
    chk("a_delivered", 32'(n_deliv), 32'd8);
    chk("a_latency", 32'(first_v - first_rd), 32'd2);
    step();
    step();
    chk("a_rd_count", 32'(rd_count), 32'd8);
    chk("a_idle_valid", 32'(m_valid), 32'd0);

    // Back-pressure: only two reads while m_ready stays low
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(32'h1000_0000 + 32'(i));
      exp_q.push_back(32'h1000_0000 + 32'(i));
    end
    m_ready = 1'b0;
    base = n_rd_seen;
    repeat (20) step();
    chk("b_read_pulses", 32'(n_rd_seen - base), 32'd2);
    chk("b_valid", 32'(m_valid), 32'd1);
    chk("b_head", m_data, 32'h1000_0000);
    drain(40);
    step();
    chk("b_rd_count", 32'(rd_count), 32'd16);
    chk("b_idle_valid", 32'(m_valid), 32'd0);

    // Flush with one word buffered and one in flight after one delivery
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(32'h2000_0000 + 32'(i));
      exp_q.push_back(32'h2000_0000 + 32'(i));
    end
    m_ready = 1'b0;
    repeat (5) step();
    chk("c_full_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    m_ready = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    chk("c_valid_after_flush", 32'(m_valid), 32'd0);
    chk("c_rd_count_kept", 32'(rd_count), 32'd17);
    want_first = 1;
    drain(40);
    chk("c_first_after_flush", first_word, 32'h2000_0003);

    // Random pushes with random back-pressure
    pushes = 0;
    for (int c = 0; c < 600 && (pushes < 50 || exp_q.size() > 0); c++) begin
      push_req = (pushes < 50) && ($urandom % 2 == 0);
      if (push_req) begin
        push_data = $urandom;
        exp_q.push_back(push_data);
        pushes++;
      end
      m_ready = 1'($urandom % 2);
      step();
    end
    push_req = 1'b0;
    chk("d_pushes", 32'(pushes), 32'd50);
    drain(20);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(32'h3000_0000 + 32'(i));
      exp_q.push_back(32'h3000_0000 + 32'(i));
    end
    m_ready = 1'b1;
    repeat (4) step();
    chk("e_pre_valid", 32'(m_valid), 32'd1);
    chk("e_pre_rd_en", 32'(fifo_rd_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_valid", 32'(m_valid), 32'd0);
    chk("e_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("e_cs", 32'(fifo_cs), 32'd0);
    chk("e_rd_count", 32'(rd_count), 32'd0);
    chk("e_m_data", m_data, 32'd0);
    exp_q = fifo_q;
    n_deliv = 0;
    prev_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain(20);

    // rd_count wraps after 65536 deliveries since reset
    need = 65536 - n_deliv;
    pushes = 0;
    m_ready = 1'b1;
    gap_chk = 1;
    last_d = -1;
    for (int c = 0; c < 66000 && n_deliv < 65536; c++) begin
      push_req = (pushes < need);
      if (push_req) begin
        push_data = 32'(pushes) ^ 32'hA5A5_0000;
        exp_q.push_back(push_data);
        pushes++;
      end
      step();
    end
    push_req = 1'b0;
    gap_chk = 0;
    chk("f_delivered", 32'(n_deliv), 32'd65536);
    chk("f_wrap", 32'(rd_count), 32'h0000);
    repeat (3) step();
    chk("f_idle_valid", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
